// File: rtl/cla_scan_display.sv
// Registered WIDTH-bit carry-lookahead adder (4-bit P/G groups) with a
// time-multiplexed hex 7-segment display of the sum, operands or group carries.
module cla_scan_display #(
  parameter  int WIDTH       = 8,
  parameter  int REFRESH_DIV = 100000,
  parameter  int BLANK_LZ    = 1,
  localparam int NDIG        = WIDTH / 4 + 1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              C_IN,
  input  logic              LOAD,
  input  logic [1:0]        MODE,
  output logic [WIDTH-1:0]  S,
  output logic              C_OUT,
  output logic              OVF,
  output logic              VALID,
  output logic [NDIG-1:0]   AN,
  output logic [6:0]        CA
);

  localparam int NG   = WIDTH / 4;
  localparam int CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW   = $clog2(NDIG);
  localparam int NSLT = 2 ** IW;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
  localparam logic [IW-1:0] IDX_TOP  = IW'(NG);

  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q;
  logic             load_q;
  logic [NG-1:0]    grp_c_q;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;

  // Carry-lookahead datapath from the captured operands
  logic [WIDTH-1:0] p, g, bit_c, sum_c;
  logic [NG-1:0]    pg, gg;
  logic [NG:0]      c;

  always_comb begin
    p     = a_q ^ b_q;
    g     = a_q & b_q;
    c     = '0;
    pg    = '0;
    gg    = '0;
    bit_c = '0;
    c[0]  = cin_q;
    for (int k = 0; k < NG; k++) begin
      pg[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      c[k+1] = gg[k] | (pg[k] & c[k]);
      // ripple inside the group only, seeded by the lookahead carry
      bit_c[4*k] = c[k];
      for (int i = 1; i < 4; i++)
        bit_c[4*k+i] = g[4*k+i-1] | (p[4*k+i-1] & bit_c[4*k+i-1]);
    end
    sum_c = p ^ bit_c;
  end

  // Scan timing
  logic          wrap;
  logic [CW-1:0] cnt_next;
  logic [IW-1:0] idx_next;

  always_comb begin
    wrap     = (cnt == CNT_LAST);
    cnt_next = wrap ? '0 : cnt + 1'b1;
    idx_next = idx;
    if (wrap) idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
  end

  function automatic logic [6:0] hex_font(input logic [3:0] v);
    case (v)
      4'h0: hex_font = 7'b1000000;
      4'h1: hex_font = 7'b1111001;
      4'h2: hex_font = 7'b0100100;
      4'h3: hex_font = 7'b0110000;
      4'h4: hex_font = 7'b0011001;
      4'h5: hex_font = 7'b0010010;
      4'h6: hex_font = 7'b0000010;
      4'h7: hex_font = 7'b1111000;
      4'h8: hex_font = 7'b0000000;
      4'h9: hex_font = 7'b0010000;
      4'hA: hex_font = 7'b0001000;
      4'hB: hex_font = 7'b0000011;
      4'hC: hex_font = 7'b1000110;
      4'hD: hex_font = 7'b0100001;
      4'hE: hex_font = 7'b0000110;
      default: hex_font = 7'b0001110;
    endcase
  endfunction

  // Digit values and leading-zero detection for the digit about to be lit
  logic [3:0]      dig [NSLT];
  logic [NSLT-1:0] nz;
  logic            blank;
  logic [NDIG-1:0] an_next;
  logic [6:0]      ca_next;

  always_comb begin
    for (int k = 0; k < NSLT; k++) dig[k] = 4'h0;
    nz = '0;
    for (int k = 0; k < NG; k++) begin
      case (MODE)
        2'd0:    dig[k] = S[4*k +: 4];
        2'd1:    dig[k] = a_q[4*k +: 4];
        2'd2:    dig[k] = b_q[4*k +: 4];
        default: dig[k] = {3'b000, grp_c_q[k]};
      endcase
      nz[k] = |dig[k];
    end
    dig[NG] = {3'b000, C_OUT};
    nz[NG]  = (MODE == 2'd0) & C_OUT;

    blank = 1'b0;
    if (MODE == 2'd0 && !VALID) blank = 1'b1;
    if (MODE != 2'd0 && idx_next == IDX_TOP) blank = 1'b1;
    if (BLANK_LZ != 0 && idx_next != '0 && (nz >> idx_next) == '0) blank = 1'b1;

    an_next = ~(NDIG'(1) << idx_next);
    ca_next = blank ? 7'b1111111 : hex_font(dig[idx_next]);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      load_q  <= 1'b0;
      S       <= '0;
      C_OUT   <= 1'b0;
      OVF     <= 1'b0;
      VALID   <= 1'b0;
      grp_c_q <= '0;
      cnt     <= '0;
      idx     <= '0;
      AN      <= '1;
      CA      <= 7'b1111111;
    end else begin
      load_q <= LOAD;
      if (LOAD) begin
        a_q   <= A;
        b_q   <= B;
        cin_q <= C_IN;
      end
      if (load_q) begin
        S       <= sum_c;
        C_OUT   <= c[NG];
        OVF     <= bit_c[WIDTH-1] ^ c[NG];
        grp_c_q <= c[NG:1];
      end
      // results reflect the last LOAD only once its pipeline stage has completed
      VALID <= ~LOAD & (VALID | load_q);
      cnt   <= cnt_next;
      idx   <= idx_next;
      AN    <= an_next;
      CA    <= ca_next;
    end
  end

endmodule

// File: tb/tb_cla_scan_display.sv
// Bench for cla_scan_display: WIDTH=8, REFRESH_DIV=4, BLANK_LZ=1.
module tb_cla_scan_display;

  localparam int W = 8;
  localparam logic [6:0] BLK = 7'b1111111;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic         cin, load;
  logic [1:0]   mode;
  logic [W-1:0] s;
  logic         c_out, ovf, valid;
  logic [2:0]   an;
  logic [6:0]   ca;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W+1:0] exp_q[$];

  cla_scan_display #(.WIDTH(W), .REFRESH_DIV(4), .BLANK_LZ(1)) dut (
    .CLOCK(clk), .RESET(rst), .A(a), .B(b), .C_IN(cin), .LOAD(load), .MODE(mode),
    .S(s), .C_OUT(c_out), .OVF(ovf), .VALID(valid), .AN(an), .CA(ca)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] font(input logic [3:0] v);
    logic [6:0] tbl [16];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return tbl[v];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected {C_OUT, OVF, S} from plain integer addition and sign rules
  task automatic push_exp(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic ec);
    logic [W:0] sum;
    logic       v;
    sum = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
    v   = (ea[W-1] == eb[W-1]) && (sum[W-1] != ea[W-1]);
    exp_q.push_back({sum[W], v, sum[W-1:0]});
  endtask

  task automatic drive_load(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    a = va; b = vb; cin = vc; load = 1'b1;
    push_exp(va, vb, vc);
  endtask

  // waits (bounded) until digit d is lit, returning the segments shown
  task automatic get_digit(input int d, output logic [6:0] seg, output bit ok);
    ok = 1'b0;
    tick();
    for (int i = 0; i < 20 && !ok; i++) begin
      if (an === ~(3'b001 << d)) ok = 1'b1;
      else tick();
    end
    seg = ca;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; a = '0; b = '0; cin = 1'b0; mode = 2'd0;
    repeat (3) tick();
    n_checks++;
    if (an !== 3'b111 || ca !== BLK) begin
      n_fail++; $display("FAIL reset_display: AN=%b CA=%b, expected 111 1111111", an, ca);
    end
    n_checks++;
    if ({c_out, ovf, valid, s} !== '0) begin
      n_fail++; $display("FAIL reset_regs: C_OUT=%b OVF=%b VALID=%b S=%h, expected all 0", c_out, ovf, valid, s);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (an !== 3'b110 || ca !== BLK) begin
      n_fail++; $display("FAIL release_first_digit: AN=%b CA=%b, expected 110 1111111", an, ca);
    end
    repeat (3) tick();
    n_checks++;
    if (an !== 3'b101) begin
      n_fail++; $display("FAIL scan_advance: AN=%b, expected 101", an);
    end
  endtask

  task automatic check_result(input string name);
    logic [W+1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL %s: no expected value queued", name);
    end else begin
      e = exp_q.pop_front();
      if ({c_out, ovf, s} !== e || valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s: C_OUT=%b OVF=%b S=%h VALID=%b, expected %b %b %h 1",
                 name, c_out, ovf, s, valid, e[W+1], e[W], e[W-1:0]);
      end
    end
  endtask

  task automatic check_digit(input string name, input int d, input logic [6:0] exp_seg);
    logic [6:0] seg;
    bit ok;
    get_digit(d, seg, ok);
    n_checks++;
    if (!ok || seg !== exp_seg) begin
      n_fail++; $display("FAIL %s: digit %0d found=%0d CA=%b, expected %b", name, d, ok, seg, exp_seg);
    end
  endtask

  task automatic single_load(input string name, input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    drive_load(va, vb, vc);
    tick();
    load = 1'b0;
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_valid_low: VALID=%b, expected 0", name, valid);
    end
    tick();
    check_result(name);
  endtask

  task automatic test_sum_basic();
    mode = 2'd0;
    single_load("sum_basic", 8'h3C, 8'h0F, 1'b0);
    check_digit("sum_basic_d0", 0, font(4'hB));
    check_digit("sum_basic_d1", 1, font(4'h4));
    check_digit("sum_basic_d2", 2, BLK);
  endtask

  task automatic test_carry_wrap();
    mode = 2'd0;
    single_load("carry_wrap", 8'hFF, 8'h01, 1'b1);
    check_digit("carry_wrap_d0", 0, font(4'h1));
    check_digit("carry_wrap_d1", 1, font(4'h0));
    check_digit("carry_wrap_d2", 2, font(4'h1));
  endtask

  task automatic test_overflow_modes();
    mode = 2'd0;
    single_load("overflow", 8'h7F, 8'h01, 1'b0);
    check_digit("ovf_sum_d0", 0, font(4'h0));
    check_digit("ovf_sum_d1", 1, font(4'h8));
    check_digit("ovf_sum_d2", 2, BLK);
    mode = 2'd1;
    check_digit("mode_a_d0", 0, font(4'hF));
    check_digit("mode_a_d1", 1, font(4'h7));
    check_digit("mode_a_d2", 2, BLK);
    mode = 2'd2;
    check_digit("mode_b_d0", 0, font(4'h1));
    check_digit("mode_b_d1", 1, BLK);
    mode = 2'd3;
    check_digit("carries_d0", 0, font(4'h1));
    check_digit("carries_d1", 1, BLK);
    check_digit("carries_d2", 2, BLK);
    mode = 2'd0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10000; i++) begin
      drive_load(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      tick();
      if (i > 0) begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        n_checks++;
        if ({c_out, ovf, s} !== e) begin
          n_fail++;
          $display("FAIL back_to_back[%0d]: C_OUT=%b OVF=%b S=%h, expected %b %b %h",
                   i, c_out, ovf, s, e[W+1], e[W], e[W-1:0]);
        end
      end
    end
    load = 1'b0;
    tick();
    check_result("back_to_back_last");
  endtask

  task automatic test_reset_mid_scan();
    logic [6:0] seg;
    bit ok;
    get_digit(2, seg, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL mid_scan_reach: AN=%b, expected 011 within bound", an);
    end
    rst = 1'b1; mode = 2'd1;
    a = 8'h55; b = 8'hAA; cin = 1'b1; load = 1'b1;
    tick();
    n_checks++;
    if (an !== 3'b111 || ca !== BLK || {c_out, ovf, valid, s} !== '0) begin
      n_fail++; $display("FAIL mid_scan_reset: AN=%b CA=%b C_OUT=%b OVF=%b VALID=%b S=%h, expected 111 1111111 0 0 0 00",
                         an, ca, c_out, ovf, valid, s);
    end
    rst = 1'b0; load = 1'b0;
    tick();
    n_checks++;
    if (an !== 3'b110 || ca !== font(4'h0) || valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_digit0: AN=%b CA=%b VALID=%b, expected 110 %b 0", an, ca, valid, font(4'h0));
    end
    tick();
    n_checks++;
    if (ca !== font(4'h0) || s !== '0 || valid !== 1'b0) begin
      n_fail++; $display("FAIL load_ignored: CA=%b S=%h VALID=%b, expected %b 00 0", ca, s, valid, font(4'h0));
    end
  endtask

  initial begin
    test_reset();
    test_sum_basic();
    test_carry_wrap();
    test_overflow_modes();
    test_back_to_back();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
